// File: rtl/systolic_result_collector.sv
// Deskews the systolic array's bottom-row results, reassembles each vector and
// queues it in a small FIFO. A credit output throttles the issue side.

module systolic_deskew_lane #(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] dl;

  always_ff @(posedge clk) begin
    if (reset) dl <= '0;
    else if (en) begin
      dl[0] <= din;
      for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
  end

  assign dout = dl[DEPTH-1];
endmodule

module systolic_result_collector #(
  parameter int OUT_WORD_SIZE = 16,
  parameter int NUM_COL       = 16,
  parameter int BASE_LAT      = 16,
  parameter int FIFO_DEPTH    = 4,
  localparam int CNT_W        = $clog2(FIFO_DEPTH+1),
  localparam int VW           = OUT_WORD_SIZE*NUM_COL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             issue_i,
  input  logic [VW-1:0]    result_i,
  output logic             issue_ready_o,
  output logic [VW-1:0]    out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);
  localparam int L    = BASE_LAT + NUM_COL - 1;
  localparam int IW   = $clog2(L+1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SUMW = ((IW > CNT_W) ? IW : CNT_W) + 1;

  logic [NUM_COL-1:0][OUT_WORD_SIZE-1:0] res_lanes, aligned;
  assign res_lanes = result_i;

  // Lane c waits NUM_COL-1-c enabled cycles; the last lane is sampled live.
  genvar c;
  generate
    for (c = 0; c < NUM_COL-1; c++) begin : g_lane
      systolic_deskew_lane #(.W(OUT_WORD_SIZE), .DEPTH(NUM_COL-1-c)) u_lane (
        .clk   (clk),
        .reset (reset),
        .en    (en_i),
        .din   (res_lanes[c]),
        .dout  (aligned[c])
      );
    end
  endgenerate
  assign aligned[NUM_COL-1] = res_lanes[NUM_COL-1];

  logic         issue_tok, tok_exit;
  logic [L-1:0] tok_pipe;
  assign issue_tok = issue_i & en_i;
  assign tok_exit  = en_i & tok_pipe[L-1];

  always_ff @(posedge clk) begin
    if (reset) tok_pipe <= '0;
    else if (en_i) tok_pipe <= {tok_pipe[L-2:0], issue_tok};
  end

  logic [IW-1:0] inflight, inflight_nxt;
  always_comb begin
    inflight_nxt = inflight;
    if (issue_tok && !tok_exit)      inflight_nxt = inflight + IW'(1);
    else if (!issue_tok && tok_exit) inflight_nxt = inflight - IW'(1);
  end

  logic [FIFO_DEPTH-1:0][VW-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             full, pop, push, drop;

  assign full        = (count_o == CNT_W'(FIFO_DEPTH));
  assign out_valid_o = (count_o != '0);
  assign pop         = out_valid_o & out_ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push        = tok_exit & (~full | pop);
  assign drop        = tok_exit & full & ~pop;
  assign out_data_o  = mem[rd_ptr];

  always_comb begin
    count_nxt = count_o;
    if (push && !pop)      count_nxt = count_o + CNT_W'(1);
    else if (!push && pop) count_nxt = count_o - CNT_W'(1);
  end

  logic [SUMW-1:0] occ_nxt;
  assign occ_nxt = SUMW'(inflight_nxt) + SUMW'(count_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_o       <= '0;
      inflight      <= '0;
      overflow_o    <= 1'b0;
      issue_ready_o <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow_o <= 1'b1;
      count_o       <= count_nxt;
      inflight      <= inflight_nxt;
      issue_ready_o <= (occ_nxt < SUMW'(FIFO_DEPTH));
    end
  end
endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized scoreboard bench: a reference model indexed by enabled-cycle count
// predicts every aligned vector and the FIFO/credit state cycle by cycle.
module tb_systolic_result_collector;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int BL = 16;
  localparam int D  = 4;
  localparam int L  = BL + N - 1;
  localparam int VW = W*N;

  logic          clk = 1'b0;
  logic          reset, en_i, issue_i, out_ready_i;
  logic [VW-1:0] result_i, out_data_o;
  logic          issue_ready_o, out_valid_o, overflow_o;
  logic [2:0]    count_o;

  always #5 clk = ~clk;

  systolic_result_collector dut (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en_i),
    .issue_i       (issue_i),
    .result_i      (result_i),
    .issue_ready_o (issue_ready_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pmode = 0;

  logic [VW-1:0] sb[$];
  logic [VW-1:0] hist[int];
  int            tok[$];
  int            en_idx = 0;
  int            msize  = 0;
  bit            movf   = 1'b0;
  bit            mrdy   = 1'b1;
  logic [15:0]   pats[3] = '{16'hFFFF, 16'h8000, 16'h7FFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] gen_data();
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++)
      v[c*W +: W] = (pmode != 0) ? pats[(c + cyc) % 3] : 16'($urandom);
    return v;
  endfunction

  // Drive one cycle, check the state left by the previous edge, then advance the model.
  task automatic step(input bit rst, input bit en, input bit iss, input bit rdy);
    logic [VW-1:0] v, t;
    bit pop, ex;
    @(posedge clk); #1;
    reset = rst; en_i = en; issue_i = iss; out_ready_i = rdy;
    result_i = gen_data();
    @(negedge clk);
    chk("out_valid", 64'(out_valid_o), 64'(msize > 0));
    chk("count", 64'(count_o), 64'(msize));
    chk("overflow", 64'(overflow_o), 64'(movf));
    chk("issue_ready", 64'(issue_ready_o), 64'(mrdy));
    if (rst) begin
      tok.delete(); sb.delete();
      msize = 0; movf = 1'b0; mrdy = 1'b1;
    end else begin
      pop = (msize > 0) && rdy;
      ex  = 1'b0;
      v   = '0;
      if (en) begin
        hist[en_idx] = result_i;
        if (tok.size() > 0 && tok[0] + L == en_idx) begin
          ex = 1'b1;
          for (int c = 0; c < N; c++) begin
            t = hist[tok[0] + BL + c];
            v[c*W +: W] = t[c*W +: W];
          end
          void'(tok.pop_front());
        end
        if (iss) tok.push_back(en_idx);
        en_idx++;
      end
      if (ex) begin
        if (msize < D || pop) begin
          sb.push_back(v);
          msize++;
        end else movf = 1'b1;
      end
      if (pop) msize--;
      mrdy = (tok.size() + msize) < D;
    end
    cyc++;
  endtask

  // Monitor: every accepted head vector must match the scoreboard head.
  initial begin
    logic [VW-1:0] exp;
    forever begin
      @(negedge clk);
      if (out_valid_o === 1'b1 && out_ready_i === 1'b1 && reset === 1'b0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output cyc=%0d got=%0h exp=none", cyc, out_data_o);
        end else begin
          exp = sb.pop_front();
          if (out_data_o !== exp) begin
            n_bad++;
            $display("FAIL out_data cyc=%0d got=%0h exp=%0h", cyc, out_data_o, exp);
          end
        end
      end
    end
  end

  initial begin
    bit r, e, i, k;
    reset = 1'b1; en_i = 1'b0; issue_i = 1'b0; out_ready_i = 1'b0; result_i = '0;
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("data_after_reset", 64'(out_data_o), 64'd0);

    // single issue, continuous enable
    step(0, 1, 1, 1);
    repeat (40) step(0, 1, 0, 1);

    // fill with four, force a fifth, then drain
    for (int n = 0; n < 5; n++) step(0, 1, 1, 0);
    repeat (36) step(0, 1, 0, 0);
    repeat (10) step(0, 1, 0, 1);
    step(1, 0, 0, 0);

    // enable gap during flight
    for (int n = 0; n < 45; n++) step(0, !(n >= 10 && n <= 14), n == 0, 1);

    // fifth vector exits into a full FIFO in the same cycle as a pop
    for (int n = 0; n < 45; n++) step(0, 1, n < 5, n == 35);
    repeat (10) step(0, 1, 0, 1);

    // reset with two vectors in flight
    for (int n = 0; n < 45; n++) step(n == 20, n != 20, n < 2, n != 20);

    // sign-sensitive lane patterns
    pmode = 1;
    for (int n = 0; n < 45; n++) step(0, 1, (n % 3 == 0) && n < 12, 1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      pmode = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 4) != 0);
      i = mrdy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      k = r ? 1'b0 : ($urandom_range(0, 2) != 0);
      step(r, e, i, k);
    end

    pmode = 0;
    repeat (60) step(0, 1, 0, 1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Receiving end of the systolic array's bottom-row result bus.
- Column c of a result vector leaves the array c cycles after column 0; this block removes that skew and reassembles each vector.
- Aligned vectors go into a small FIFO with a valid/ready interface to downstream logic.
- A credit output lets the input feeder throttle issues so the FIFO never overflows.

Parameters:
- OUT_WORD_SIZE, 16, width of one result lane.
- NUM_COL, 16, lanes per result vector (array columns).
- BASE_LAT, 16, enabled cycles from an issue to lane 0 of its result appearing on result_i.
- FIFO_DEPTH, 4, aligned vectors buffered; power of two, minimum 2.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en_i  input  1  the same enable that drives the array; low freezes the deskew pipeline.
- issue_i  input  1  a new input vector entered the array this cycle; qualified by en_i.
- result_i  input  OUT_WORD_SIZE*NUM_COL  array bottom-row outputs; lane c is bits [OUT_WORD_SIZE*c +: OUT_WORD_SIZE].
- issue_ready_o  output  1  credit available; the feeder may issue.
- out_data_o  output  OUT_WORD_SIZE*NUM_COL  aligned vector at the FIFO head, same lane packing as result_i.
- out_valid_o  output  1  FIFO not empty.
- out_ready_i  input  1  downstream accepts the head vector.
- count_o  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow_o  output  1  sticky; set when an aligned vector is dropped.

Behaviour:
- Reset (synchronous, active-high):
  - Clears deskew registers, token pipeline, in-flight counter, FIFO pointers and overflow_o.
  - Output values the cycle after reset is sampled: out_valid_o=0, out_data_o=0, count_o=0, overflow_o=0, issue_ready_o=1.
  - Reset mid-operation discards all in-flight vectors; nothing they carried ever appears at the output.
- Deskew:
  - Lane c passes through a delay line of NUM_COL-1-c registers; lane NUM_COL-1 is combinational pass-through into the capture point.
  - The delay lines shift only when en_i=1 and hold when en_i=0.
- Token pipeline:
  - issue_i&en_i enters a 1-bit shift register of length L = BASE_LAT+NUM_COL-1, which shifts only when en_i=1.
  - The token exits together with the aligned data: L enabled cycles after the issue, in the same en_i=1 cycle that the last lane is sampled.
- FIFO write: on token exit, the aligned vector is written if the FIFO is not full or a pop occurs in the same cycle.
  - Otherwise the vector is dropped, overflow_o is set and holds until reset, and occupancy is unchanged.
- FIFO read:
  - A pop occurs when out_valid_o&out_ready_i.
  - out_data_o always shows the head entry and is registered (no combinational path from result_i).
  - A written vector is visible on out_valid_o the cycle after the write, so continuous-enable latency from issue to out_valid_o is L+1 cycles.
- Push and pop in the same cycle:
  - When full: both are performed, count_o is unchanged, no overflow.
  - When empty: only the push takes effect; the pushed data is visible the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Credit:
  - An in-flight counter (width clog2(L+1)) increments on issue_i&en_i and decrements on token exit; both in one cycle leave it unchanged.
  - issue_ready_o = (inflight + count_o) < FIFO_DEPTH, registered from the current state.
  - Issuing while issue_ready_o=0 is legal but may cause overflow.
- en_i=0 does not affect the FIFO read side: pops and out_valid_o continue.
- Arithmetic: lane data is passed through bit-exact with no sign interpretation; counters never wrap.

Test Plan:
- Defaults (L=31). Issue at cycle 0; drive lane c = 16'h0100+c at cycle 16+c; out_ready_i=1 -> out_valid_o=1 at cycle 32, out_data_o lanes 0..15 = 0x0100..0x010F, count_o returns to 0 after one cycle.
- Issue on 4 consecutive cycles with out_ready_i=0 -> issue_ready_o=0 from the cycle after the 4th issue; count_o=4. A 5th forced issue -> overflow_o=1 and count_o stays 4. Then draining gives the 4 vectors in issue order with intact data.
- Issue at cycle 0, en_i=0 for cycles 10-14, array data delayed identically -> out_valid_o at cycle 37 with correct data; count_o and out_valid_o unaffected while en_i=0.
- FIFO full (4), out_ready_i=1 in the same cycle a 5th vector exits -> count_o stays 4, overflow_o=0, head advances, the new vector ends up at the tail.
- Reset asserted for 1 cycle at cycle 20 with 2 vectors in flight -> the next cycle shows out_valid_o=0, count_o=0, issue_ready_o=1; no output ever appears for those vectors.
- Lanes driven 16'hFFFF / 16'h8000 / 16'h7FFF alternately -> output bit-exact, no sign extension or saturation.
